// File: rtl/xor_gate_pkg.sv
// Shared constants and helpers for the xor_gate block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   WIDTH_MAX     - largest supported operand width
//   CNT_W_DEFAULT - default width of the a != b event counter
//   clog2_plus1() - bits needed to hold a population count of a w-bit vector
package xor_gate_pkg;

  localparam int WIDTH_MAX     = 64;
  localparam int CNT_W_DEFAULT = 16;

  // A w-bit vector can hold 0..w ones, so the count needs clog2(w+1) bits.
  function automatic int clog2_plus1(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/xor_popcount.sv
// Combinational population count of a WIDTH-bit vector.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows input continuously.
//
// Ports:
//   vec - input vector to count
//   cnt - number of 1-bits in vec
module xor_popcount
  import xor_gate_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0]              vec,
  output logic [clog2_plus1(WIDTH)-1:0] cnt
);

  localparam int OW = clog2_plus1(WIDTH);

  always_comb begin
    cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt = cnt + OW'(vec[i]);
    end
  end

endmodule

// File: rtl/xor_gate.sv
// Bitwise XOR with a combinational output, a registered capture stage, its popcount and a saturating a != b counter.
// Latency: y is 0 cycles; y_q/ones_q/out_valid (and parity_q) are 1 cycle after an in_valid edge.
// Backpressure: none; every in_valid cycle is captured, out_valid is a one-cycle strobe.
//
// Optional feature: define XOR_GATE_PARITY_EN to add parity_q (registered XOR-reduction of the captured result).
//
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   a, b, in_valid  - operands and their qualifier
//   y               - combinational a ^ b (ignores clk/rst/in_valid)
//   y_q, ones_q     - registered a ^ b and its popcount, held while idle
//   out_valid       - high the cycle after a capture
//   diff_cnt        - saturating count of captures with a != b
//   parity_q        - (XOR_GATE_PARITY_EN only) registered parity of y_q
module xor_gate
  import xor_gate_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [WIDTH-1:0]              a,
  input  logic [WIDTH-1:0]              b,
  input  logic                          in_valid,
  output logic [WIDTH-1:0]              y,
  output logic [WIDTH-1:0]              y_q,
  output logic                          out_valid,
  output logic [clog2_plus1(WIDTH)-1:0] ones_q,
  output logic [CNT_W-1:0]              diff_cnt
`ifdef XOR_GATE_PARITY_EN
  ,
  output logic                          parity_q
`endif
);

  localparam int OW = clog2_plus1(WIDTH);

  logic [WIDTH-1:0] x;
  logic [OW-1:0]    x_ones;

  logic [WIDTH-1:0] y_d;
  logic [OW-1:0]    ones_d;
  logic             out_valid_d, out_valid_q;
  logic [CNT_W-1:0] diff_cnt_d, diff_cnt_q;

  assign x = a ^ b;
  assign y = x;

  xor_popcount #(.WIDTH(WIDTH)) u_popcount (
    .vec (x),
    .cnt (x_ones)
  );

  // Operands are only looked at under in_valid, so unknown a/b while idle
  // cannot reach any state.
  always_comb begin
    y_d         = y_q;
    ones_d      = ones_q;
    out_valid_d = 1'b0;
    diff_cnt_d  = diff_cnt_q;
    if (in_valid) begin
      y_d         = x;
      ones_d      = x_ones;
      out_valid_d = 1'b1;
      // Saturate at all-ones rather than wrap.
      if ((|x) && (diff_cnt_q != {CNT_W{1'b1}})) begin
        diff_cnt_d = diff_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q         <= '0;
      ones_q      <= '0;
      out_valid_q <= 1'b0;
      diff_cnt_q  <= '0;
    end else begin
      y_q         <= y_d;
      ones_q      <= ones_d;
      out_valid_q <= out_valid_d;
      diff_cnt_q  <= diff_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign diff_cnt  = diff_cnt_q;

`ifdef XOR_GATE_PARITY_EN
  logic parity_d;

  always_comb begin
    parity_d = parity_q;
    if (in_valid) begin
      parity_d = ^x;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`endif

endmodule

// File: tb/tb_xor_gate.sv
// Bench for xor_gate: directed checks on a WIDTH=1/CNT_W=2 instance and a
// randomized scoreboard run on a WIDTH=8/CNT_W=16 instance.
module tb_xor_gate;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // WIDTH=1, CNT_W=2 instance
  logic       rst1, iv1, ov1;
  logic [0:0] a1, b1, y1, yq1, ones1;
  logic [1:0] cnt1;

  // WIDTH=8, CNT_W=16 instance
  logic        rst8, iv8, ov8;
  logic [7:0]  a8, b8, y8, yq8;
  logic [3:0]  ones8;
  logic [15:0] cnt8;

`ifdef XOR_GATE_PARITY_EN
  logic par1, par8;
`endif

  xor_gate #(.WIDTH(1), .CNT_W(2)) u_dut1 (
    .clk       (clk),
    .rst       (rst1),
    .a         (a1),
    .b         (b1),
    .in_valid  (iv1),
    .y         (y1),
    .y_q       (yq1),
    .out_valid (ov1),
    .ones_q    (ones1),
    .diff_cnt  (cnt1)
`ifdef XOR_GATE_PARITY_EN
    ,
    .parity_q  (par1)
`endif
  );

  xor_gate #(.WIDTH(8), .CNT_W(16)) u_dut8 (
    .clk       (clk),
    .rst       (rst8),
    .a         (a8),
    .b         (b8),
    .in_valid  (iv8),
    .y         (y8),
    .y_q       (yq8),
    .out_valid (ov8),
    .ones_q    (ones8),
    .diff_cnt  (cnt8)
`ifdef XOR_GATE_PARITY_EN
    ,
    .parity_q  (par8)
`endif
  );

  typedef struct packed {
    logic [7:0]  y;
    logic [3:0]  ones;
    logic [15:0] cnt;
    logic        par;
  } exp_t;

  exp_t sb[$];
  int   model_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus on the 8-bit instance. The reference model is a
  // plain integer count plus XOR/popcount of the operands; the expected
  // response is queued at the capture edge.
  task automatic drive8(input logic r, input logic v, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    #1;
    rst8 = r; iv8 = v; a8 = a; b8 = b;
    #1;
    chk("y8_comb", 64'(y8), 64'(a ^ b));
    @(posedge clk);
    if (r) begin
      model_cnt = 0;
    end else if (v) begin
      if (a != b) model_cnt = (model_cnt < 65535) ? model_cnt + 1 : 65535;
      e.y    = a ^ b;
      e.ones = 4'($countones(a ^ b));
      e.cnt  = 16'(model_cnt);
      e.par  = ($countones(a ^ b) % 2) == 1;
      sb.push_back(e);
    end
  endtask

  // Monitor: whenever the 8-bit instance presents out_valid, pop and compare.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (ov8 === 1'b1) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL sb_unexpected: out_valid=1 with y_q=%0h, expected no output", yq8);
        end else begin
          e = sb.pop_front();
          chk("sb_y_q",     64'(yq8),   64'(e.y));
          chk("sb_ones_q",  64'(ones8), 64'(e.ones));
          chk("sb_diff_cnt",64'(cnt8),  64'(e.cnt));
`ifdef XOR_GATE_PARITY_EN
          chk("sb_parity_q",64'(par8),  64'(e.par));
`endif
        end
      end else if (sb.size() != 0) begin
        vectors++;
        miscompares++;
        $display("FAIL sb_missing: out_valid=%b, expected 1 with %0d queued", ov8, sb.size());
        sb.delete();
      end
    end
  end

  initial begin
    logic       r, v;
    logic [7:0] ra, rb;

    rst1 = 1'b1; iv1 = 1'b0; a1 = '0; b1 = '0;
    rst8 = 1'b1; iv8 = 1'b0; a8 = '0; b8 = '0;
    model_cnt = 0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state.
    chk("rst_y_q1",   64'(yq1),   64'd0);
    chk("rst_ones1",  64'(ones1), 64'd0);
    chk("rst_ov1",    64'(ov1),   64'd0);
    chk("rst_cnt1",   64'(cnt1),  64'd0);
    chk("rst_y_q8",   64'(yq8),   64'd0);
    chk("rst_ones8",  64'(ones8), 64'd0);
    chk("rst_ov8",    64'(ov8),   64'd0);
    chk("rst_cnt8",   64'(cnt8),  64'd0);
    rst1 = 1'b0;
    rst8 = 1'b0;

    // Truth table, 10 ns apart, y checked right after each change.
    for (int i = 0; i < 4; i++) begin
      a1 = 1'(i % 2);
      b1 = 1'(i / 2);
      #1;
      chk("truth_y", 64'(y1), 64'(a1 ^ b1));
      #9;
    end

    @(posedge clk); #1;
    // Registered capture.
    a1 = 1'b1; b1 = 1'b0; iv1 = 1'b1;
    @(posedge clk); #1;
    chk("cap1_y_q",  64'(yq1),   64'd1);
    chk("cap1_ones", 64'(ones1), 64'd1);
    chk("cap1_ov",   64'(ov1),   64'd1);
    chk("cap1_cnt",  64'(cnt1),  64'd1);
    a1 = 1'b1; b1 = 1'b1;
    @(posedge clk); #1;
    chk("cap2_y_q",  64'(yq1),   64'd0);
    chk("cap2_ones", 64'(ones1), 64'd0);
    chk("cap2_cnt",  64'(cnt1),  64'd1);
    a1 = 1'b0; b1 = 1'b1;
    @(posedge clk); #1;
    chk("cap3_y_q",  64'(yq1),   64'd1);
    chk("cap3_cnt",  64'(cnt1),  64'd2);

    // Hold for 3 idle cycles with unknown operands.
    iv1 = 1'b0;
    a1 = 'x; b1 = 'x;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("hold_y_q",  64'(yq1),   64'd1);
      chk("hold_ov",   64'(ov1),   64'd0);
      chk("hold_ones", 64'(ones1), 64'd1);
      chk("hold_cnt",  64'(cnt1),  64'd2);
    end

    // Reset wins over a simultaneous capture; y stays combinational.
    rst1 = 1'b1; iv1 = 1'b1; a1 = 1'b1; b1 = 1'b0;
    @(posedge clk); #1;
    chk("rstpri_y_q", 64'(yq1),  64'd0);
    chk("rstpri_ov",  64'(ov1),  64'd0);
    chk("rstpri_cnt", 64'(cnt1), 64'd0);
    chk("rstpri_y",   64'(y1),   64'd1);

    // First capture after reset, then saturation of the 2-bit counter.
    rst1 = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      chk("sat_cnt", 64'(cnt1), 64'((k < 3) ? k : 3));
      chk("sat_ov",  64'(ov1),  64'd1);
      chk("sat_y_q", 64'(yq1),  64'd1);
    end
    iv1 = 1'b0;

    // 8-bit directed vector, then randomized traffic through the scoreboard.
    drive8(1'b0, 1'b1, 8'hF0, 8'h3C);
    for (int n = 0; n < 400; n++) begin
      r  = ($urandom_range(0, 31) == 0);
      v  = ($urandom_range(0, 3) != 0);
      ra = 8'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : 8'($urandom);
      drive8(r, v, ra, rb);
    end
    drive8(1'b0, 1'b0, 8'h00, 8'h00);
    drive8(1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk); #1;
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
